// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
//   Shared definitions for the EX-stage multiply/divide unit and the decode
//   stage: RV32M/RV64M funct3 encodings and operand sign-handling helpers.
package ex_muldiv_unit_pkg;

   localparam logic [2:0] MD_OP_MUL    = 3'b000;
   localparam logic [2:0] MD_OP_MULH   = 3'b001;
   localparam logic [2:0] MD_OP_MULHSU = 3'b010;
   localparam logic [2:0] MD_OP_MULHU  = 3'b011;
   localparam logic [2:0] MD_OP_DIV    = 3'b100;
   localparam logic [2:0] MD_OP_DIVU   = 3'b101;
   localparam logic [2:0] MD_OP_REM    = 3'b110;
   localparam logic [2:0] MD_OP_REMU   = 3'b111;

   // rs1 is interpreted as signed
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_REM);
   endfunction

   // rs2 is interpreted as signed
   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
   endfunction

   // divide-family ops (funct3[2] set)
   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. Multiplies retire
//   MUL_BITS_PER_CYCLE multiplier bits per cycle via shift-add; divides use
//   restoring division, one quotient bit per cycle. Both paths share one
//   2*XLEN accumulator and one adder. Sign correction happens in FIXUP.
//   Divide-by-zero and signed overflow are resolved at accept.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready_o=1, waiting for start_i
//   CALC  | iterating; cnt_q counts down to terminal count 0
//   FIXUP | apply sign correction, register result
//   DONE  | done_o pulse, result_o/rd_addr_o valid; no accept here
//
// Ports
//   clk, rst            clock, async active-high reset
//   flush_i             kill in-flight op (no done_o, result_o untouched)
//   start_i, op_i       request and funct3 opcode, sampled when ready_o=1
//   operand_a_i/_b_i    rs1/rs2 values
//   rd_addr_i           destination tag, returned on rd_addr_o
//   ready_o, busy_o     decoded from state register
//   done_o              one-cycle completion pulse
//   result_o            result, held until the next done_o
//   rd_addr_o           tag of the completed op
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN               = 32,
   parameter int MUL_BITS_PER_CYCLE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic [4:0]      rd_addr_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);

   localparam int MB        = MUL_BITS_PER_CYCLE;
   localparam int AW        = XLEN + MB + 1;
   localparam int CW        = $clog2(XLEN);
   localparam int MUL_ITERS = XLEN / MB;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   if ((XLEN < 8) || (XLEN % 2 != 0) ||
       !((MB == 1) || (MB == 2) || (MB == 4) || (MB == 8)) ||
       (XLEN % MB != 0)) begin : g_param_check
      $error("ex_muldiv_unit: illegal XLEN / MUL_BITS_PER_CYCLE combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     opnd_q;
   logic [CW-1:0]       cnt_q;
   logic [2:0]          op_q;
   logic [4:0]          rd_q;
   logic                neg_q;
   logic                neg_rem_q;

   logic                accept;
   logic                a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                div_by_zero, div_ovf, special;
   logic [XLEN-1:0]     special_res;

   logic [AW-1:0]       add_x, add_y, add_sum;
   logic                add_cin;
   logic                div_borrow;
   logic [XLEN-1:0]     rem_new;
   logic [2*XLEN-1:0]   div_next, mul_next;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

   assign ready_o = (state_q == S_IDLE);
   assign busy_o  = (state_q != S_IDLE);
   assign accept  = ready_o && start_i && !flush_i;

   always_comb begin
      a_neg       = op_signed_a(op_i) & operand_a_i[XLEN-1];
      b_neg       = op_signed_b(op_i) & operand_b_i[XLEN-1];
      a_mag       = a_neg ? -operand_a_i : operand_a_i;
      b_mag       = b_neg ? -operand_b_i : operand_b_i;
      div_by_zero = op_is_div(op_i) && (operand_b_i == '0);
      div_ovf     = ((op_i == MD_OP_DIV) || (op_i == MD_OP_REM)) &&
                    (operand_a_i == MOST_NEG) && (operand_b_i == ALL_ONES);
      special     = div_by_zero || div_ovf;
      // op_i[1] selects remainder within the divide family
      if (div_by_zero) special_res = op_i[1] ? operand_a_i : ALL_ONES;
      else             special_res = op_i[1] ? '0 : MOST_NEG;
   end

   // Shared adder. Divide: trial remainder {rem, next dividend bit} minus
   // divisor (subtract via inverted operand and carry-in). Multiply: upper
   // accumulator half plus multiplicand times the current multiplier digit.
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      if (op_is_div(op_q)) begin
         add_x   = AW'(acc_q[2*XLEN-1:XLEN-1]);
         add_y   = ~AW'(opnd_q);
         add_cin = 1'b1;
      end else begin
         add_x   = AW'(acc_q[2*XLEN-1:XLEN]);
         add_y   = AW'(opnd_q) * AW'(acc_q[MB-1:0]);
      end
      add_sum = add_x + add_y + AW'(add_cin);
   end

   always_comb begin
      div_borrow = add_sum[AW-1];
      rem_new    = div_borrow ? acc_q[2*XLEN-2:XLEN-1] : add_sum[XLEN-1:0];
      div_next   = {rem_new, acc_q[XLEN-2:0], ~div_borrow};
      mul_next   = (2*XLEN)'({add_sum[XLEN+MB-1:0], acc_q[XLEN-1:0]} >> MB);
   end

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (op_is_div(op_q))       fix_res = op_q[1] ? rem_fix : quo_fix;
      else if (op_q == MD_OP_MUL) fix_res = prod_fix[XLEN-1:0];
      else                       fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIXUP;
         S_FIXUP: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_i && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         done_o    <= 1'b0;
         result_o  <= '0;
         rd_addr_o <= '0;
      end else begin
         state_q <= state_d;
         done_o  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q      <= op_i;
                  rd_q      <= rd_addr_i;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  if (op_is_div(op_i)) begin
                     acc_q  <= {{XLEN{1'b0}}, a_mag};
                     opnd_q <= b_mag;
                     cnt_q  <= CW'(XLEN - 1);
                  end else begin
                     acc_q  <= {{XLEN{1'b0}}, b_mag};
                     opnd_q <= a_mag;
                     cnt_q  <= CW'(MUL_ITERS - 1);
                  end
                  if (special) begin
                     result_o  <= special_res;
                     rd_addr_o <= rd_addr_i;
                     done_o    <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               acc_q <= op_is_div(op_q) ? div_next : mul_next;
               cnt_q <= cnt_q - CW'(1);
            end
            S_FIXUP: begin
               if (!flush_i) begin
                  result_o  <= fix_res;
                  rd_addr_o <= rd_q;
                  done_o    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  rd;
   logic        ready, busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   logic        start1;
   logic [2:0]  op1;
   logic [31:0] a1, b1;
   logic [4:0]  rd1;
   logic        ready1, busy1, done1;
   logic [31:0] result1;
   logic [4:0]  rd_out1;
   logic        flush1;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .start_i(start), .op_i(op),
      .operand_a_i(a), .operand_b_i(b), .rd_addr_i(rd),
      .ready_o(ready), .busy_o(busy), .done_o(done),
      .result_o(result), .rd_addr_o(rd_out)
   );

   ex_muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .flush_i(flush1), .start_i(start1), .op_i(op1),
      .operand_a_i(a1), .operand_b_i(b1), .rd_addr_i(rd1),
      .ready_o(ready1), .busy_o(busy1), .done_o(done1),
      .result_o(result1), .rd_addr_o(rd_out1)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   // Reference model built from native wide arithmetic
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0]        sx, sy, ux, uy, p;
      logic signed [31:0] q;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'b0, x};
      uy = {32'b0, y};
      p  = '0;
      case (o)
         MD_OP_MUL:    begin p = ux * uy; return p[31:0];  end
         MD_OP_MULH:   begin p = sx * sy; return p[63:32]; end
         MD_OP_MULHSU: begin p = sx * uy; return p[63:32]; end
         MD_OP_MULHU:  begin p = ux * uy; return p[63:32]; end
         MD_OP_DIV: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = $signed(x) / $signed(y);
            return q;
         end
         MD_OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         MD_OP_REM: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            q = $signed(x) % $signed(y);
            return q;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (!o[2]) return 10;
      if (y == 0) return 1;
      if ((o == MD_OP_DIV || o == MD_OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Scoreboard: every done_o must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done with result %0h want no done", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, " result"}, {32'b0, result}, {32'b0, e.res});
            chk({e.name, " rd"}, {59'b0, rd_out}, {59'b0, e.rd});
         end
      end
   end

   // Called at a negedge; returns at the negedge of cycle 1
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input logic [31:0] res, input bit expect_done,
                        input string name);
      int n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL %s ready_timeout: got ready=0 want 1", name);
      end
      op    = o;
      a     = x;
      b     = y;
      rd    = t;
      start = 1'b1;
      if (expect_done) sb.push_back('{res, t, name});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int n = 1;
      bit busy_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
      chk({name, " busy"}, {63'b0, busy_ok & busy}, 64'd1);
      @(negedge clk);
      chk({name, " ready_after"}, {63'b0, ready}, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl[14];

   initial begin
      logic [31:0] prev;
      int          n;

      rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
      start1 = 1'b0; flush1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; rd1 = '0;

      tbl[0]  = '{MD_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10};
      tbl[1]  = '{MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10};
      tbl[2]  = '{MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10};
      tbl[3]  = '{MD_OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 10};
      tbl[4]  = '{MD_OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 10};
      tbl[5]  = '{MD_OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
      tbl[6]  = '{MD_OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
      tbl[7]  = '{MD_OP_DIVU,   32'd100,       32'd7,         32'd14,        34};
      tbl[8]  = '{MD_OP_REMU,   32'd100,       32'd7,         32'd2,         34};
      tbl[9]  = '{MD_OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
      tbl[10] = '{MD_OP_DIVU,   32'd1234,      32'd0,         32'hFFFF_FFFF, 1};
      tbl[11] = '{MD_OP_REM,    32'd5,         32'd0,         32'd5,         1};
      tbl[12] = '{MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[13] = '{MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

      repeat (3) @(negedge clk);
      chk("reset ready",  {63'b0, ready},  64'd1);
      chk("reset busy",   {63'b0, busy},   64'd0);
      chk("reset done",   {63'b0, done},   64'd0);
      chk("reset result", {32'b0, result}, 64'd0);
      chk("reset rd",     {59'b0, rd_out}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         issue(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].res, 1'b1, nm);
         wait_done(nm, tbl[i].lat);
      end

      for (int i = 0; i < 12; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         string       nm;
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         nm = $sformatf("rnd%0d", i);
         issue(ro, ra, rb, 5'(i + 3), model(ro, ra, rb), 1'b1, nm);
         wait_done(nm, model_lat(ro, ra, rb));
      end

      // Flush a DIV in cycle 5; a start during busy in cycle 3 must be ignored
      prev = result;
      issue(MD_OP_DIV, 32'd1000, 32'd3, 5'd9, 32'd0, 1'b0, "flushed_div");
      @(negedge clk);
      @(negedge clk);
      op = MD_OP_MUL; a = 32'd1; b = 32'd1; rd = 5'd30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush ready_cycle6", {63'b0, ready}, 64'd1);
      chk("flush done_low", {63'b0, done}, 64'd0);
      chk("flush result_held", {32'b0, result}, {32'b0, prev});
      issue(MD_OP_MUL, 32'd3, 32'd4, 5'd11, 32'd12, 1'b1, "mul_after_flush");
      wait_done("mul_after_flush", 10);

      // Async reset in cycle 3 of a MULHU
      issue(MD_OP_MULHU, 32'hFFFF_FFFF, 32'h1234_5678, 5'd12, 32'd0, 1'b0, "reset_mulhu");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst ready",  {63'b0, ready},  64'd1);
      chk("midrst busy",   {63'b0, busy},   64'd0);
      chk("midrst done",   {63'b0, done},   64'd0);
      chk("midrst result", {32'b0, result}, 64'd0);
      chk("midrst rd",     {59'b0, rd_out}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(MD_OP_MUL, 32'd5, 32'd9, 5'd13, 32'd45, 1'b1, "mul_after_rst");
      wait_done("mul_after_rst", 10);

      // One bit per cycle: MUL completes in cycle 34
      op1 = MD_OP_MUL; a1 = 32'd5; b1 = 32'd6; rd1 = 5'd21; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      n = 1;
      while (!done1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mbpc1 latency", 64'(n), 64'd34);
      chk("mbpc1 result", {32'b0, result1}, 64'd30);
      chk("mbpc1 rd", {59'b0, rd_out1}, 64'd21);

      repeat (2) @(negedge clk);
      chk("scoreboard empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
